filtr_sekwencer: RTL

Sample-rate scheduler and handshake controller for one notch-filter instance (filtr_a-style: data_in/sample_trig/data_out/filter_done).
- Generates the sample tick from a programmable clock divider.
- Latches the input sample, fires a one-cycle sample_trig, waits for filter_done with a timeout.
- Hands the result downstream over valid/ready; counts dropped (overrun) samples.
- Sits between the ADC-side sample register and the filter core inside the filter top level.

---
 rtl/filtr_pkg.sv | 17 +
 rtl/filtr_tick_gen.sv | 37 +++
 rtl/filtr_sekwencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/filtr_pkg.sv
// filtr_sekwencer shared types and default widths.
// FSM encoding is fixed so status taps can decode it directly.
package filtr_pkg;

  localparam int DATA_SIZE_D = 5;
  localparam int DIV_WIDTH_D = 16;
  localparam int TIMEOUT_D   = 64;
  localparam int OVR_WIDTH_D = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/filtr_tick_gen.sv
// Programmable sample-period divider.
// Fires tick when cnt reaches div, so a shrunk div ticks at once.
module filtr_tick_gen
  import filtr_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign tick = en && (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/filtr_sekwencer.sv
// Sample scheduler and handshake controller for one filter core.
// Trigger, bounded wait for done, then valid/ready hand-off.
module filtr_sekwencer
  import filtr_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_D,
  parameter int DIV_WIDTH = DIV_WIDTH_D,
  parameter int TIMEOUT   = TIMEOUT_D,
  parameter int OVR_WIDTH = OVR_WIDTH_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] f_data_in,
  output logic                 f_sample_trig,
  input  logic [DATA_SIZE-1:0] f_data_out,
  input  logic                 f_filter_done,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [OVR_WIDTH-1:0] overrun_cnt,
  output logic                 timeout_err,
  input  logic                 clear_status
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_e state_q;
  state_e state_d;

  logic [TW-1:0]        timer_q;
  logic [TW-1:0]        timer_d;
  logic [DATA_SIZE-1:0] f_data_in_q;
  logic [DATA_SIZE-1:0] f_data_in_d;
  logic [DATA_SIZE-1:0] out_data_q;
  logic [DATA_SIZE-1:0] out_data_d;
  logic                 out_valid_q;
  logic                 out_valid_d;
  logic [OVR_WIDTH-1:0] ovr_q;
  logic [OVR_WIDTH-1:0] ovr_d;
  logic                 terr_q;
  logic                 terr_d;

  logic tick;
  logic capture;
  logic in_wait;
  logic done_hit;
  logic time_up;
  logic handshake;
  logic ovr_inc;

  filtr_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .div  (div),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (tick) state_d = ST_TRIG;
      ST_TRIG: state_d = ST_WAIT;
      ST_WAIT: begin
        if (f_filter_done) begin
          state_d = ST_HOLD;
        end else if (time_up) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: if (handshake) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    f_sample_trig = (state_q == ST_TRIG);
    busy          = (state_q != ST_IDLE);
    capture       = (state_q == ST_IDLE) && tick;
    in_wait       = (state_q == ST_WAIT);
    done_hit      = in_wait && f_filter_done;
    time_up       = in_wait && (timer_q == T_LAST);
    handshake     = (state_q == ST_HOLD) && out_valid_q && out_ready;
    ovr_inc       = tick && (state_q != ST_IDLE);
  end

  always_comb begin
    timer_d     = timer_q;
    f_data_in_d = f_data_in_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovr_d       = ovr_q;
    terr_d      = terr_q;

    if (f_sample_trig) begin
      timer_d = '0;
    end else if (in_wait) begin
      timer_d = timer_q + 1'b1;
    end

    if (capture) begin
      f_data_in_d = data_in;
    end

    if (done_hit) begin
      out_data_d  = f_data_out;
      out_valid_d = 1'b1;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    // Clearing wins over a same-cycle increment or timeout.
    if (clear_status) begin
      ovr_d  = '0;
      terr_d = 1'b0;
    end else begin
      if (ovr_inc && (ovr_q != '1)) begin
        ovr_d = ovr_q + 1'b1;
      end
      if (time_up && !f_filter_done) begin
        terr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q     <= '0;
      f_data_in_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      f_data_in_q <= f_data_in_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
      terr_q      <= terr_d;
    end
  end

  assign f_data_in   = f_data_in_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign overrun_cnt = ovr_q;
  assign timeout_err = terr_q;

endmodule
